// File: rtl/fixedpoint_pkg.sv
// Shared widths, rounding-mode constant and signed range helpers for the
// fixed-point requantizer.
package fixedpoint_pkg;

   localparam int DEF_BP = 48;
   localparam int DEF_BO = 8;
   localparam int DEF_BS = 6;

   // Only one rounding mode exists today; the type leaves room for more.
   typedef enum logic [0:0] {ROUND_HALF_UP = 1'b0} round_mode_t;
   localparam round_mode_t ROUND_MODE = ROUND_HALF_UP;

   function automatic logic signed [63:0] smax(input int bo);
      return (64'sd1 <<< (bo - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] smin(input int bo);
      return -(64'sd1 <<< (bo - 1));
   endfunction

endpackage

// File: rtl/fixedpoint_pipe_stage.sv
// Valid/ready register slice: loads when empty or when the next slice moves.
// Handshake: a slot moves forward when its consumer enable is high; en is the
// combinational "can accept" flag handed back to the producer.
module fixedpoint_pipe_stage #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         src_valid,
   input  logic [W-1:0] d,
   input  logic         sink_en,
   output logic         en,
   output logic         valid,
   output logic [W-1:0] q
);

   assign en = !valid || sink_en;

   always_ff @(posedge clk) begin
      if (clr) begin
         valid <= 1'b0;
         q     <= '0;
      end else if (en) begin
         valid <= src_valid;
         // Payload only captured with a real sample so idle inputs are ignored.
         if (src_valid) q <= d;
      end
   end

endmodule

// File: rtl/fixedpoint_requantizer.sv
// Two-stage round-half-up shift and saturate from BP to BO signed bits.
// Optional saturation counter enabled by FIXEDPOINT_REQUANT_SATCOUNT_EN.
module fixedpoint_requantizer
   import fixedpoint_pkg::*;
#(
   parameter int BP = DEF_BP,
   parameter int BO = DEF_BO,
   parameter int BS = DEF_BS
`ifdef FIXEDPOINT_REQUANT_SATCOUNT_EN
   ,
   parameter int BN = 32
`endif
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [BP-1:0] in_data,
   input  logic [BS-1:0] in_shift,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [BO-1:0] out_data,
   output logic          out_sat
`ifdef FIXEDPOINT_REQUANT_SATCOUNT_EN
   ,
   output logic [BN-1:0] sat_count
`endif
);

   localparam int SHIFT_MAX = BP - 1;

   logic          en1, en2, v1, v2;
   logic [BS-1:0] s_eff;
   logic [BP:0]   ext, rnd, sum, r_in, r1;
   logic [BO:0]   sat_d, q2;

   assign s_eff = (32'(in_shift) > SHIFT_MAX) ? BS'(SHIFT_MAX) : in_shift;

   // One guard bit keeps the rounding add from overflowing at the range edges.
   assign ext  = {in_data[BP-1], in_data};
   assign rnd  = (s_eff == '0) ? '0 : ((BP+1)'(1) << (s_eff - 1'b1));
   assign sum  = ext + rnd;
   assign r_in = $signed(sum) >>> s_eff;

   fixedpoint_pipe_stage #(.W(BP+1)) u_stage1 (
      .clk       (clk),
      .clr       (clr),
      .src_valid (in_valid),
      .d         (r_in),
      .sink_en   (en2),
      .en        (en1),
      .valid     (v1),
      .q         (r1)
   );

   always_comb begin
      sat_d = {1'b0, r1[BO-1:0]};
      if ($signed(r1) > smax(BO))      sat_d = {1'b1, BO'(smax(BO))};
      else if ($signed(r1) < smin(BO)) sat_d = {1'b1, BO'(smin(BO))};
   end

   fixedpoint_pipe_stage #(.W(BO+1)) u_stage2 (
      .clk       (clk),
      .clr       (clr),
      .src_valid (v1),
      .d         (sat_d),
      .sink_en   (out_ready),
      .en        (en2),
      .valid     (v2),
      .q         (q2)
   );

   assign in_ready  = en1;
   assign out_valid = v2;
   assign out_sat   = q2[BO];
   assign out_data  = q2[BO-1:0];

`ifdef FIXEDPOINT_REQUANT_SATCOUNT_EN
   always_ff @(posedge clk) begin
      if (clr) begin
         sat_count <= '0;
      end else if (out_valid && out_ready && out_sat && (sat_count != '1)) begin
         sat_count <= sat_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_fixedpoint_requantizer.sv
// Directed scoreboard bench for fixedpoint_requantizer (BP=48, BO=8, BS=6).
module tb_fixedpoint_requantizer;

   localparam int BP = 48;
   localparam int BO = 8;
   localparam int BS = 6;

   logic          clk = 1'b0;
   logic          clr = 1'b1;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b1;
   logic [BP-1:0] in_data = '0;
   logic [BS-1:0] in_shift = '0;
   logic          in_ready, out_valid, out_sat;
   logic [BO-1:0] out_data;
`ifdef FIXEDPOINT_REQUANT_SATCOUNT_EN
   logic [31:0]   sat_count;
`endif

   fixedpoint_requantizer #(.BP(BP), .BO(BO), .BS(BS)) dut (
      .clk       (clk),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shift  (in_shift),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat)
`ifdef FIXEDPOINT_REQUANT_SATCOUNT_EN
      ,
      .sat_count (sat_count)
`endif
   );

   // clock / reset
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   bit saw_stall = 1'b0;

   // scoreboard: {sat, data} and the pre-edge cycle of the transfer (-1 = no latency check)
   logic [BO:0] exp_q[$];
   int          lat_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // driver
   task automatic send(input longint d, input int sh, input int ed, input bit es, input bit lat);
      int waitc = 0;
      bit ok = 1'b1;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = BP'(d);
      in_shift = BS'(sh);
      forever begin
         #1;
         if (in_ready) break;
         saw_stall = 1'b1;
         if (waitc >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=stalled required=accepted");
            ok = 1'b0;
            break;
         end
         @(negedge clk);
         waitc++;
      end
      if (ok) begin
         exp_q.push_back({es, BO'(ed)});
         lat_q.push_back(lat ? cyc : -1);
         @(posedge clk);
      end
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout actual=%0d required=0 pending", exp_q.size());
      end
   endtask

   task automatic do_clr();
      @(negedge clk);
      clr = 1'b1;
      exp_q.delete();
      lat_q.delete();
      @(negedge clk);
      clr = 1'b0;
   endtask

   // monitor: pops on every output transfer, checks hold while stalled
   bit          held = 1'b0;
   logic [BO:0] held_v;
   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (clr) begin
            held = 1'b0;
         end else begin
            if (held) begin
               check("stall_valid_hold", 64'(out_valid), 64'd1);
               check("stall_data_hold", 64'({out_sat, out_data}), 64'(held_v));
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_output actual=%0h required=none", out_data);
               end else begin
                  logic [BO:0] e;
                  int t;
                  e = exp_q.pop_front();
                  t = lat_q.pop_front();
                  check("out_data", 64'(out_data), 64'(e[BO-1:0]));
                  check("out_sat", 64'(out_sat), 64'(e[BO]));
                  if (t >= 0) check("latency", 64'(cyc - t), 64'd2);
               end
            end
            held   = out_valid && !out_ready;
            held_v = {out_sat, out_data};
         end
      end
   end

   initial begin
      repeat (2) @(negedge clk);
      clr = 1'b0;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_out_sat", 64'(out_sat), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef FIXEDPOINT_REQUANT_SATCOUNT_EN
      check("rst_sat_count", 64'(sat_count), 64'd0);
`endif

      // basic value with latency, rounding signs, saturation
      send(300, 2, 75, 1'b0, 1'b1);
      send(-6, 2, -1, 1'b0, 1'b0);
      send(-5, 1, -2, 1'b0, 1'b0);
      send(5, 1, 3, 1'b0, 1'b0);
      send(7, 0, 7, 1'b0, 1'b0);
      send(-7, 1, -3, 1'b0, 1'b0);
      send(1000, 0, 127, 1'b1, 1'b0);
      send(-1000, 0, -128, 1'b1, 1'b0);
      drain();
`ifdef FIXEDPOINT_REQUANT_SATCOUNT_EN
      check("sat_count_two", 64'(sat_count), 64'd2);
`endif

      // range edges and shift clamp
      send(128, 0, 127, 1'b1, 1'b0);
      send(-128, 0, -128, 1'b0, 1'b0);
      send(254, 1, 127, 1'b0, 1'b0);
      send(255, 1, 127, 1'b1, 1'b0);
      send(64'sd140737488355327, 63, 1, 1'b0, 1'b0);
      send(-64'sd140737488355328, 63, -1, 1'b0, 1'b0);
      drain();

      // backpressure: out_ready low on cycles 3-7 of a 10-sample stream
      saw_stall = 1'b0;
      fork
         begin
            for (int v = 1; v <= 10; v++) send(longint'(v), 0, v, 1'b0, 1'b0);
         end
         begin
            for (int k = 1; k <= 12; k++) begin
               @(negedge clk);
               out_ready = !(k >= 3 && k <= 7);
            end
         end
      join
      out_ready = 1'b1;
      drain();
      check("bp_in_ready_drop", 64'(saw_stall), 64'd1);

      // clear mid-stream with both stages full and downstream stalled
      @(negedge clk);
      out_ready = 1'b0;
      send(11, 0, 11, 1'b0, 1'b0);
      send(2000, 0, 127, 1'b1, 1'b0);
      @(negedge clk);
      #1;
      check("full_in_ready", 64'(in_ready), 64'd0);
      do_clr();
      #1;
      check("clr_out_valid", 64'(out_valid), 64'd0);
      check("clr_out_data", 64'(out_data), 64'd0);
      check("clr_out_sat", 64'(out_sat), 64'd0);
      check("clr_in_ready", 64'(in_ready), 64'd1);
`ifdef FIXEDPOINT_REQUANT_SATCOUNT_EN
      check("clr_sat_count", 64'(sat_count), 64'd0);
`endif
      out_ready = 1'b1;
      send(42, 0, 42, 1'b0, 1'b1);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
